// File: rtl/bsg_fpu_special_sched.sv
// Two-operand fp16 add/sub sequencer: one shared classifier, special cases resolved locally.
// Optional build macro: BSG_FPU_SPECIAL_SCHED_DAZ_EN (denormals treated as signed zero).
`timescale 1ns/1ps

module bsg_fpu_special_sched #(
  parameter int tag_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [15:0]            a_i,
  input  logic [15:0]            b_i,
  input  logic                   sub_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   issue_v_o,
  input  logic                   issue_ready_i,
  output logic [15:0]            issue_a_o,
  output logic [15:0]            issue_b_o,
  output logic [tag_width_p-1:0] issue_tag_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [15:0]            z_o,
  output logic                   invalid_o,
  output logic [tag_width_p-1:0] tag_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLS_A,
    CLS_B,
    DECIDE,
    ISSUE,
    RESULT
  } stateT;

  typedef struct packed {
    logic zero;
    logic nan;
    logic sigNan;
    logic infty;
    logic denormal;
    logic sign;
  } flagsT;

`ifdef BSG_FPU_SPECIAL_SCHED_DAZ_EN
  localparam logic DazEn = 1'b1;
`else
  localparam logic DazEn = 1'b0;
`endif

  stateT                  state_q;
  logic [15:0]            opA_q;
  logic [15:0]            opB_q;
  logic                   sub_q;
  logic [tag_width_p-1:0] tag_q;
  flagsT                  flagsA_q;
  flagsT                  flagsB_q;
  logic [15:0]            z_q;
  logic                   invalid_q;
  logic                   v_q;
  logic                   issueV_q;
  logic                   ready_q;

  logic [15:0] clsIn;
  logic        clsSignFlip;
  flagsT       clsFlags;

  // Single classifier, steered to B (with effective sign) only while in CLS_B.
  always_comb begin
    clsIn       = (state_q == CLS_B) ? opB_q : opA_q;
    clsSignFlip = (state_q == CLS_B) & sub_q;
    clsFlags.zero     = (clsIn[14:10] == 5'd0)  && (clsIn[9:0] == 10'd0);
    clsFlags.denormal = (clsIn[14:10] == 5'd0)  && (clsIn[9:0] != 10'd0);
    clsFlags.infty    = (clsIn[14:10] == 5'h1F) && (clsIn[9:0] == 10'd0);
    clsFlags.nan      = (clsIn[14:10] == 5'h1F) && (clsIn[9:0] != 10'd0);
    clsFlags.sigNan   = clsFlags.nan && !clsIn[9];
    clsFlags.sign     = clsIn[15] ^ clsSignFlip;
  end

  logic        zeroA;
  logic        zeroB;
  logic [15:0] survA;
  logic [15:0] survB;
  logic        special_d;
  logic [15:0] z_d;
  logic        invalid_d;

  always_comb begin
    zeroA = flagsA_q.zero | (DazEn & flagsA_q.denormal);
    zeroB = flagsB_q.zero | (DazEn & flagsB_q.denormal);
    survA = (DazEn & flagsA_q.denormal) ? {flagsA_q.sign, 15'b0}
                                        : {flagsA_q.sign, opA_q[14:0]};
    survB = (DazEn & flagsB_q.denormal) ? {flagsB_q.sign, 15'b0}
                                        : {flagsB_q.sign, opB_q[14:0]};
    special_d = 1'b1;
    z_d       = 16'h0000;
    invalid_d = 1'b0;
    if (flagsA_q.nan || flagsB_q.nan) begin
      z_d       = 16'h7E00;
      invalid_d = flagsA_q.sigNan | flagsB_q.sigNan;
    end else if (flagsA_q.infty && flagsB_q.infty && (flagsA_q.sign != flagsB_q.sign)) begin
      z_d       = 16'h7E00;
      invalid_d = 1'b1;
    end else if (flagsA_q.infty) begin
      z_d = {flagsA_q.sign, 15'h7C00};
    end else if (flagsB_q.infty) begin
      z_d = {flagsB_q.sign, 15'h7C00};
    end else if (zeroA && zeroB) begin
      z_d = {flagsA_q.sign & flagsB_q.sign, 15'b0};
    end else if (zeroA) begin
      z_d = survB;
    end else if (zeroB) begin
      z_d = survA;
    end else begin
      special_d = 1'b0;
    end
  end

  // Sequencer; latched operands stay frozen until the next accept so outputs hold under back-pressure.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      sub_q     <= 1'b0;
      tag_q     <= '0;
      flagsA_q  <= '0;
      flagsB_q  <= '0;
      z_q       <= '0;
      invalid_q <= 1'b0;
      v_q       <= 1'b0;
      issueV_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (v_i && ready_q) begin
            opA_q   <= a_i;
            opB_q   <= b_i;
            sub_q   <= sub_i;
            tag_q   <= tag_i;
            ready_q <= 1'b0;
            state_q <= CLS_A;
          end
        end
        CLS_A: begin
          flagsA_q <= clsFlags;
          state_q  <= CLS_B;
        end
        CLS_B: begin
          flagsB_q <= clsFlags;
          state_q  <= DECIDE;
        end
        DECIDE: begin
          if (special_d) begin
            z_q       <= z_d;
            invalid_q <= invalid_d;
            v_q       <= 1'b1;
            state_q   <= RESULT;
          end else begin
            issueV_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready_i) begin
            issueV_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        RESULT: begin
          if (yumi_i) begin
            v_q     <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign issue_v_o   = issueV_q;
  assign issue_a_o   = opA_q;
  assign issue_b_o   = {opB_q[15] ^ sub_q, opB_q[14:0]};
  assign issue_tag_o = tag_q;
  assign v_o         = v_q;
  assign z_o         = z_q;
  assign invalid_o   = invalid_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_bsg_fpu_special_sched.sv
// Scoreboard bench for bsg_fpu_special_sched: directed test-plan vectors, random pairs, back-pressure and reset.
`timescale 1ns/1ps

module tb_bsg_fpu_special_sched;

  localparam int TagW = 4;

`ifdef BSG_FPU_SPECIAL_SCHED_DAZ_EN
  localparam bit DazEn = 1'b1;
`else
  localparam bit DazEn = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            v_i;
  logic            ready_o;
  logic [15:0]     a_i;
  logic [15:0]     b_i;
  logic            sub_i;
  logic [TagW-1:0] tag_i;
  logic            issue_v_o;
  logic            issue_ready_i;
  logic [15:0]     issue_a_o;
  logic [15:0]     issue_b_o;
  logic [TagW-1:0] issue_tag_o;
  logic            v_o;
  logic            yumi_i;
  logic [15:0]     z_o;
  logic            invalid_o;
  logic [TagW-1:0] tag_o;

  bsg_fpu_special_sched #(.tag_width_p(TagW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .tag_i(tag_i),
    .issue_v_o(issue_v_o), .issue_ready_i(issue_ready_i),
    .issue_a_o(issue_a_o), .issue_b_o(issue_b_o), .issue_tag_o(issue_tag_o),
    .v_o(v_o), .yumi_i(yumi_i), .z_o(z_o), .invalid_o(invalid_o), .tag_o(tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            special;
    logic [15:0]     z;
    logic            inv;
    logic [15:0]     ia;
    logic [15:0]     ib;
    logic [TagW-1:0] tag;
  } expT;

  expT             sbQ[$];
  int              checkCount = 0;
  int              errorCount = 0;
  logic [TagW-1:0] nextTag = '0;

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Independent reference for the special-case rules, used for the random pairs.
  function automatic void refModel(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                   output logic special, output logic [15:0] z, output logic inv);
    logic [15:0] be;
    logic aNan, bNan, aSnan, bSnan, aInf, bInf, aZero, bZero;
    be    = {b[15] ^ sub, b[14:0]};
    aNan  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bNan  = (be[14:10] == 5'h1F) && (be[9:0] != 0);
    aSnan = aNan && (a[9] == 1'b0);
    bSnan = bNan && (be[9] == 1'b0);
    aInf  = (a[14:0] == 15'h7C00);
    bInf  = (be[14:0] == 15'h7C00);
    aZero = (a[14:0] == 0) || (DazEn && a[14:10] == 0);
    bZero = (be[14:0] == 0) || (DazEn && be[14:10] == 0);
    special = 1'b1;
    inv     = 1'b0;
    z       = 16'h0000;
    if (aNan || bNan) begin
      z = 16'h7E00; inv = aSnan || bSnan;
    end else if (aInf && bInf && a[15] != be[15]) begin
      z = 16'h7E00; inv = 1'b1;
    end else if (aInf) begin
      z = a;
    end else if (bInf) begin
      z = be;
    end else if (aZero && bZero) begin
      z = {a[15] & be[15], 15'b0};
    end else if (aZero) begin
      z = be;
    end else if (bZero) begin
      z = a;
    end else begin
      special = 1'b0;
    end
  endfunction

  function automatic logic [15:0] pickOperand();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v = {v[15], 15'h7C00};
      1: v = {v[15], 5'h1F, v[9:1], 1'b1};
      2: v = {v[15], 15'h0000};
      3: v = {v[15], 5'h00, v[9:1], 1'b1};
      default: if (v[14:10] == 5'h1F || v[14:10] == 5'h00) v[14:10] = 5'h0F;
    endcase
    return v;
  endfunction

  // Drives one request, waits for acceptance and pushes the expected response.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub,
                               input logic special, input logic [15:0] z, input logic inv);
    expT e;
    int  waitCnt;
    waitCnt = 0;
    e.special = special;
    e.z       = z;
    e.inv     = inv;
    e.ia      = a;
    e.ib      = {b[15] ^ sub, b[14:0]};
    e.tag     = nextTag;
    a_i = a; b_i = b; sub_i = sub; tag_i = nextTag; v_i = 1'b1;
    while (!ready_o && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("readyWait", 32'(ready_o), 1);
    sbQ.push_back(e);
    tick();
    v_i = 1'b0;
    nextTag++;
  endtask

  // Pops the scoreboard when the DUT answers; holds the handshake low for 'hold' cycles.
  task automatic checkResponse(input int hold);
    expT e;
    int  cnt;
    cnt = 0;
    while (!(v_o || issue_v_o) && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("respValid", 32'(v_o | issue_v_o), 1);
    checkOutput("latency", cnt, 3);
    checkOutput("sbNonEmpty", 32'(sbQ.size() != 0), 1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    if (hold > 0) begin
      if (e.special) issue_ready_i = 1'b1;
      else           yumi_i        = 1'b1;
    end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        tick();
        checkOutput("readyHeld", 32'(ready_o), 0);
      end
      checkOutput("vOut", 32'(v_o), 32'(e.special));
      checkOutput("issueV", 32'(issue_v_o), 32'(!e.special));
      if (e.special) begin
        checkOutput("z", 32'(z_o), 32'(e.z));
        checkOutput("invalid", 32'(invalid_o), 32'(e.inv));
        checkOutput("tag", 32'(tag_o), 32'(e.tag));
      end else begin
        checkOutput("issueA", 32'(issue_a_o), 32'(e.ia));
        checkOutput("issueB", 32'(issue_b_o), 32'(e.ib));
        checkOutput("issueTag", 32'(issue_tag_o), 32'(e.tag));
      end
    end
    issue_ready_i = 1'b0;
    yumi_i        = 1'b0;
    if (e.special) yumi_i        = 1'b1;
    else           issue_ready_i = 1'b1;
    tick();
    yumi_i        = 1'b0;
    issue_ready_i = 1'b0;
    checkOutput("validDrop", 32'(v_o | issue_v_o), 0);
    checkOutput("readyRise", 32'(ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        sp;
    logic [15:0] zz;
    logic        iv;
    logic [15:0] ra, rb;
    logic        rs;
    logic        sawValid;

    reset_i = 1'b1; v_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; tag_i = '0;
    yumi_i = 1'b0; issue_ready_i = 1'b0;
    tick();
    tick();
    checkOutput("rstReady", 32'(ready_o), 0);
    checkOutput("rstV", 32'(v_o), 0);
    checkOutput("rstIssueV", 32'(issue_v_o), 0);
    checkOutput("rstZ", 32'(z_o), 0);
    checkOutput("rstInvalid", 32'(invalid_o), 0);
    checkOutput("rstIssueA", 32'(issue_a_o), 0);
    checkOutput("rstIssueB", 32'(issue_b_o), 0);
    checkOutput("rstTags", 32'({tag_o, issue_tag_o}), 0);
    reset_i = 1'b0;
    tick();
    checkOutput("readyAfterReset", 32'(ready_o), 1);

    applyStimulus(16'h3C00, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0); checkResponse(0);
    applyStimulus(16'h3C00, 16'h4000, 1'b1, 1'b0, 16'h0000, 1'b0); checkResponse(0);
    applyStimulus(16'h7C00, 16'h7C00, 1'b1, 1'b1, 16'h7E00, 1'b1); checkResponse(0);
    applyStimulus(16'h7C00, 16'h7C00, 1'b0, 1'b1, 16'h7C00, 1'b0); checkResponse(0);
    applyStimulus(16'h3C00, 16'h7C00, 1'b1, 1'b1, 16'hFC00, 1'b0); checkResponse(0);
    applyStimulus(16'h7C01, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 1'b1); checkResponse(0);
    applyStimulus(16'h7E00, 16'h7C01, 1'b0, 1'b1, 16'h7E00, 1'b1); checkResponse(0);
    applyStimulus(16'h7E00, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 1'b0); checkResponse(0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0); checkResponse(0);
    applyStimulus(16'h0000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b0); checkResponse(0);
    applyStimulus(16'h0000, 16'h3C00, 1'b1, 1'b1, 16'hBC00, 1'b0); checkResponse(0);
    applyStimulus(16'hC200, 16'h0000, 1'b1, 1'b1, 16'hC200, 1'b0); checkResponse(0);
    if (DazEn) applyStimulus(16'h0001, 16'h3C00, 1'b0, 1'b1, 16'h3C00, 1'b0);
    else       applyStimulus(16'h0001, 16'h3C00, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkResponse(0);

    // Back-pressure on both ports with the next request already waiting on v_i.
    applyStimulus(16'h7C00, 16'h7C00, 1'b1, 1'b1, 16'h7E00, 1'b1);
    a_i = 16'h3C00; b_i = 16'h4000; sub_i = 1'b0; tag_i = nextTag; v_i = 1'b1;
    checkResponse(3);
    applyStimulus(16'h3C00, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0);
    a_i = 16'h0000; b_i = 16'h3C00; sub_i = 1'b1; tag_i = nextTag; v_i = 1'b1;
    checkResponse(3);
    applyStimulus(16'h0000, 16'h3C00, 1'b1, 1'b1, 16'hBC00, 1'b0);
    checkResponse(1);

    for (int n = 0; n < 20; n++) begin
      ra = pickOperand();
      rb = pickOperand();
      rs = 1'($urandom_range(0, 1));
      refModel(ra, rb, rs, sp, zz, iv);
      applyStimulus(ra, rb, rs, sp, zz, iv);
      checkResponse($urandom_range(0, 2));
    end

    // Reset while the request sits in CLS_B: it must vanish without any output.
    a_i = 16'h3C00; b_i = 16'h4000; sub_i = 1'b0; tag_i = 4'hA; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
    checkOutput("midRstReady", 32'(ready_o), 0);
    checkOutput("midRstValids", 32'({v_o, issue_v_o}), 0);
    checkOutput("midRstData", 32'({issue_a_o, issue_b_o}), 0);
    checkOutput("midRstZTag", 32'({z_o, invalid_o, tag_o, issue_tag_o}), 0);
    reset_i = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawValid = sawValid | v_o | issue_v_o;
    end
    checkOutput("noOutAfterReset", 32'(sawValid), 0);
    checkOutput("readyPostReset", 32'(ready_o), 1);

    applyStimulus(16'h4000, 16'h3C00, 1'b1, 1'b0, 16'h0000, 1'b0);
    checkResponse(0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
